fc_argmax: RTL
==============

FC_ARGMAX -- requirements
Module: fc_argmax

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the activation width of the upstream FC neuron.
REQ-002 SHALL have parameter IN_W, default WIDTH*2+7 (23), the neuron output width after ReLU.
REQ-003 SHALL have parameter N_CLASS, default 10, the number of neuron outputs per frame.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, a neuron score is present on in_data.
REQ-007 SHALL have port in_ready, output, 1, the block accepts a score this cycle.
REQ-008 SHALL have port in_data, input, IN_W, the neuron score, unsigned because it is non-negative after ReLU.
REQ-009 SHALL have port out_valid, output, 1, a frame result is held on the outputs.
REQ-010 SHALL have port out_ready, input, 1, the consumer takes the result.
REQ-011 SHALL have port out_class, output, $clog2(N_CLASS), the index of the winning neuron.
REQ-012 SHALL have port out_max, output, IN_W, the winning score, present only under FC_ARGMAX_SCORE_EN.

Function
REQ-013 SHALL implement two states: ACC (collecting scores) and HOLD (presenting the result).
REQ-014 SHALL drive in_ready=1 only in ACC and out_valid=1 only in HOLD.
REQ-015 SHALL accept a beat when in_valid&&in_ready; idle cycles (in_valid=0) SHALL not change state, count or best.
REQ-016 SHALL keep a beat counter cnt, 0..N_CLASS-1, incremented per accepted beat; the accepted beat's index equals cnt.
REQ-017 SHALL load best score/index unconditionally on beat 0.
REQ-018 SHALL replace best on later beats only when in_data > best score (strict unsigned compare), so ties resolve to the lowest index.
REQ-019 SHALL, on accepting beat cnt==N_CLASS-1, include that beat in the compare, enter HOLD and reset cnt to 0; out_valid rises the next cycle (latency 1 cycle from last beat).
REQ-020 SHALL hold out_class/out_max stable while out_valid&&!out_ready.
REQ-021 SHALL, on out_valid&&out_ready, return to ACC the next cycle with best cleared; out_valid falls and in_ready rises in the same cycle.
REQ-022 SHALL, when in_valid is asserted in HOLD, leave the beat unaccepted (backpressure); no beat is lost or counted.
REQ-023 SHALL handle N_CLASS=1 as a single beat directly producing class 0.
REQ-024 SHALL sustain throughput of N_CLASS beats plus 1 result cycle per frame when out_ready is held high.

Reset
REQ-025 SHALL, on rst assertion at any time, including mid-frame or in HOLD, asynchronously force state=ACC, cnt=0, best score=0, best index=0, out_valid=0, out_class=0, out_max=0.
REQ-026 SHALL make in_ready=1 in the first cycle after rst deasserts; partial frames are discarded.

Configuration
REQ-027 SHALL, with FC_ARGMAX_SCORE_EN defined, expose out_max carrying the winning score, valid with out_valid.
REQ-028 SHALL, without FC_ARGMAX_SCORE_EN, omit the out_max port; the internal best-score register remains for compare; out_class behaviour is identical.

Verification
REQ-029 Frame 5,9,3,12,0,7,1,2,11,4 with out_ready=1 -> out_valid one cycle after beat 9, out_class=3, out_max=12.
REQ-030 Frame of all 20 values -> out_class=0 (tie to lowest); frame of all 0 -> out_class=0, out_max=0.
REQ-031 out_ready=0 for 5 cycles after result while in_valid=1 -> in_ready=0, outputs stable, no beat accepted; after out_ready pulse the next frame result is correct.
REQ-032 rst pulsed after beat 4 of a frame, then a full frame with max 0x7FFFFF at index 9 -> out_class=9, out_max=0x7FFFFF; the pre-reset beats have no influence.
REQ-033 Random in_valid gaps (~50%) over 100 frames versus a reference model -> out_class/out_max always match and the frame count equals 100.
REQ-034 Build without FC_ARGMAX_SCORE_EN and rerun REQ-029 -> out_class=3 and the port list lacks out_max.

Source files
------------

// File: rtl/fc_argmax_if.sv
// rtl/fc_argmax_if.sv - score-in / class-out handshake bundle for fc_argmax
// FC_ARGMAX_SCORE_EN adds the out_max winning-score signal.
interface fc_argmax_if #(
    parameter int IN_W = 23,
    parameter int CW   = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [CW-1:0]   out_class;
`ifdef FC_ARGMAX_SCORE_EN
    logic [IN_W-1:0] out_max;
`endif

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_class
`ifdef FC_ARGMAX_SCORE_EN
        , input out_max
`endif
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_class
`ifdef FC_ARGMAX_SCORE_EN
        , output out_max
`endif
    );
endinterface

// File: rtl/fc_argmax.sv
// rtl/fc_argmax.sv - streaming argmax over N_CLASS neuron scores per frame
// FC_ARGMAX_SCORE_EN: also present the winning score on out_max.
module fc_argmax #(
    parameter int WIDTH   = 8,
    parameter int IN_W    = WIDTH * 2 + 7,
    parameter int N_CLASS = 10
) (
    input logic         clk,
    input logic         rst,
    fc_argmax_if.slave  bus
);
    localparam int CW = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_CLASS - 1);

    typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   best_idx_q, best_idx_d;
    logic [IN_W-1:0] best_q, best_d;
    logic            beat;
    logic            take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACC;
            cnt_q      <= '0;
            best_idx_q <= '0;
            best_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            best_idx_q <= best_idx_d;
            best_q     <= best_d;
        end
    end

    // Strict compare keeps the earliest index on ties; beat 0 always loads.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        best_idx_d = best_idx_q;
        best_d     = best_q;
        beat       = bus.in_valid && (state_q == ACC);
        take       = beat && ((cnt_q == '0) || (bus.in_data > best_q));
        case (state_q)
            ACC: begin
                if (beat) begin
                    if (take) begin
                        best_d     = bus.in_data;
                        best_idx_d = cnt_q;
                    end
                    if (cnt_q == LAST) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d    = ACC;
                    best_d     = '0;
                    best_idx_d = '0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == ACC);
        bus.out_valid = (state_q == HOLD);
        bus.out_class = best_idx_q;
`ifdef FC_ARGMAX_SCORE_EN
        bus.out_max   = best_q;
`endif
    end
endmodule
